// File: rtl/seg_display_pkg.sv
// ============================================================================
//  seg_display_pkg
//  Shared constants and state encoding for the seven-segment display arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package seg_display_pkg;

  localparam int DISP_W                = 24;
  localparam int DEFAULT_DWELL_CYCLES  = 50_000_000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage : seg_display_pkg

`default_nettype wire

// File: rtl/seg_display_arbiter_rr_pick.sv
// ============================================================================
//  rr_pick
//  Combinational round-robin search over a request vector from a start index.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [OWN_W-1:0]   i_start,
  input  logic               i_excl_en,
  output logic               o_found,
  output logic [OWN_W-1:0]   o_idx
);

  localparam logic [OWN_W:0] c_num_req = (OWN_W+1)'(NUM_REQ);

  // With exclusion on, the last position of the scan (start-1) is the current
  // owner, so it is skipped and can never win against itself.
  always_comb begin
    logic [OWN_W:0] w_pos;
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, i_start} + (OWN_W+1)'(k);
      if (w_pos >= c_num_req) begin
        w_pos = w_pos - c_num_req;
      end
      if (!o_found && i_req[w_pos[OWN_W-1:0]] && !(i_excl_en && (k == NUM_REQ-1))) begin
        o_found = 1'b1;
        o_idx   = w_pos[OWN_W-1:0];
      end
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
//  seg_display_arbiter
//  Round-robin arbiter with minimum dwell that time-shares the 24-bit display.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int CNT_W        = 26,
  parameter int OWN_W        = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [DISP_W*NUM_REQ-1:0] i_req_data,
  input  logic                      i_lock,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [OWN_W-1:0]          o_owner,
  output logic [DISP_W-1:0]         o_disp_out,
  output logic                      o_disp_valid
);

  localparam logic [CNT_W-1:0] c_reload  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [OWN_W-1:0] c_last_ix = OWN_W'(NUM_REQ - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [OWN_W-1:0]    r_ptr;
  logic                r_fresh;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [OWN_W-1:0]    r_owner;
  logic [DISP_W-1:0]   r_disp;
  logic                r_valid;

  state_t              w_nxt_state;
  logic [CNT_W-1:0]    w_nxt_cnt;
  logic [OWN_W-1:0]    w_nxt_ptr;
  logic                w_nxt_fresh;
  logic [NUM_REQ-1:0]  w_nxt_gnt;
  logic [OWN_W-1:0]    w_nxt_owner;
  logic [DISP_W-1:0]   w_nxt_disp;
  logic                w_nxt_valid;

  logic [DISP_W-1:0]   w_req_data [NUM_REQ];
  logic [OWN_W-1:0]    w_start;
  logic                w_excl;
  logic                w_found;
  logic [OWN_W-1:0]    w_win;
  logic                w_take;
  logic                w_owner_req;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_data[g] = i_req_data[g*DISP_W +: DISP_W];
  end

  // The very first search after reset begins at requester 0; afterwards it
  // begins one past the last winner.
  assign w_start     = r_fresh ? '0 : ((r_ptr == c_last_ix) ? '0 : r_ptr + 1'b1);
  assign w_excl      = (r_state == ST_HOLD);
  assign w_owner_req = i_req[r_owner];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_rr_pick (
    .i_req     (i_req),
    .i_start   (w_start),
    .i_excl_en (w_excl),
    .o_found   (w_found),
    .o_idx     (w_win)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_ptr   = r_ptr;
    w_nxt_fresh = r_fresh;
    w_nxt_gnt   = r_gnt;
    w_nxt_owner = r_owner;
    w_nxt_disp  = r_disp;
    w_nxt_valid = r_valid;
    w_take      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_nxt_valid = 1'b0;
        w_take      = w_found;
      end
      ST_HOLD: begin
        if (!w_owner_req) begin
          // A release always wins, even against expiry or LOCK.
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_gnt   = '0;
            w_nxt_valid = 1'b0;
          end
        end else if ((r_cnt == '0) && !i_lock) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_nxt_cnt  = c_reload;
            w_nxt_disp = w_req_data[r_owner];
          end
        end else begin
          if (r_cnt != '0) begin
            w_nxt_cnt = r_cnt - 1'b1;
          end
          w_nxt_disp = w_req_data[r_owner];
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    if (w_take) begin
      w_nxt_state = ST_HOLD;
      w_nxt_cnt   = c_reload;
      w_nxt_ptr   = w_win;
      w_nxt_fresh = 1'b0;
      w_nxt_owner = w_win;
      w_nxt_disp  = w_req_data[w_win];
      w_nxt_valid = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        w_nxt_gnt[i] = (w_win == OWN_W'(i));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_fresh <= 1'b1;
      r_gnt   <= '0;
      r_owner <= '0;
      r_disp  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_ptr   <= w_nxt_ptr;
      r_fresh <= w_nxt_fresh;
      r_gnt   <= w_nxt_gnt;
      r_owner <= w_nxt_owner;
      r_disp  <= w_nxt_disp;
      r_valid <= w_nxt_valid;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_owner      = r_owner;
  assign o_disp_out   = r_disp;
  assign o_disp_valid = r_valid;

endmodule : seg_display_arbiter

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
//  tb_seg_display_arbiter
//  Self-checking bench: reference model scoreboard plus hand-derived vectors.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

  localparam int N     = 4;
  localparam int DWELL = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          lock;
  logic [23:0]   data [N];
  logic [24*N-1:0] req_data;
  logic [N-1:0]  gnt;
  logic [1:0]    owner;
  logic [23:0]   disp_out;
  logic          disp_valid;

  assign req_data = {data[3], data[2], data[1], data[0]};

  seg_display_arbiter #(
    .NUM_REQ      (N),
    .DWELL_CYCLES (DWELL),
    .CNT_W        (3),
    .OWN_W        (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_req_data   (req_data),
    .i_lock       (lock),
    .o_gnt        (gnt),
    .o_owner      (owner),
    .o_disp_out   (disp_out),
    .o_disp_valid (disp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic [23:0]  disp;
    logic         valid;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [N-1:0] req;
    logic         lock;
    logic [N-1:0] exp_gnt;
    logic         exp_valid;
  } vec_t;

  // Reference model state
  bit          m_hold;
  bit          m_fresh;
  int          m_ptr;
  int          m_cnt;
  logic [N-1:0] m_gnt;
  int          m_owner;
  logic [23:0] m_disp;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_fresh = 1; m_ptr = 0; m_cnt = 0;
    m_gnt = '0; m_owner = 0; m_disp = '0; m_valid = 1'b0;
    q.delete();
  endtask

  task automatic model_grant(input int w);
    m_gnt = '0;
    m_gnt[w] = 1'b1;
    m_owner = w; m_disp = data[w]; m_valid = 1'b1;
    m_cnt = DWELL - 1; m_ptr = w; m_hold = 1; m_fresh = 0;
  endtask

  task automatic model_step();
    int  w;
    bit  f;
    int  start;
    exp_t e;
    f = 0; w = 0;
    if (!m_hold) begin
      start = m_fresh ? 0 : (m_ptr + 1) % N;
      for (int k = 0; k < N; k++)
        if (!f && req[(start + k) % N]) begin f = 1; w = (start + k) % N; end
      if (f) model_grant(w);
      else m_valid = 1'b0;
    end else begin
      for (int k = 1; k < N; k++)
        if (!f && req[(m_owner + k) % N]) begin f = 1; w = (m_owner + k) % N; end
      if (!req[m_owner]) begin
        if (f) model_grant(w);
        else begin m_hold = 0; m_gnt = '0; m_valid = 1'b0; end
      end else if (m_cnt == 0 && !lock) begin
        if (f) model_grant(w);
        else begin m_cnt = DWELL - 1; m_disp = data[m_owner]; end
      end else begin
        if (m_cnt != 0) m_cnt--;
        m_disp = data[m_owner];
      end
    end
    e.gnt = m_gnt; e.owner = 2'(m_owner); e.disp = m_disp; e.valid = m_valid;
    q.push_back(e);
  endtask

  // One clock: model predicts from the inputs now applied, DUT output checked after the edge.
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_gnt",   32'(gnt),        32'(e.gnt));
    chk("sb_owner", 32'(owner),      32'(e.owner));
    chk("sb_disp",  32'(disp_out),   32'(e.disp));
    chk("sb_valid", 32'(disp_valid), 32'(e.valid));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; lock = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt",   32'(gnt),        32'h0);
    chk("rst_owner", 32'(owner),      32'h0);
    chk("rst_disp",  32'(disp_out),   32'h0);
    chk("rst_valid", 32'(disp_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [30];

    // Round-robin with REQ=1011 from reset: owners 0,1,3,0 for four edges each.
    for (int i = 0; i < 16; i++) begin
      vt[i].req = 4'b1011; vt[i].lock = 1'b0; vt[i].exp_valid = 1'b1;
      vt[i].exp_gnt = (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : (i < 12) ? 4'b1000 : 4'b0001;
    end
    // Owner 0 has expired; LOCK keeps it for 12 cycles, then requester 1 takes over.
    for (int i = 16; i < 28; i++) begin
      vt[i].req = 4'b0111; vt[i].lock = 1'b1; vt[i].exp_gnt = 4'b0001; vt[i].exp_valid = 1'b1;
    end
    for (int i = 28; i < 30; i++) begin
      vt[i].req = 4'b0111; vt[i].lock = 1'b0; vt[i].exp_gnt = 4'b0010; vt[i].exp_valid = 1'b1;
    end

    rst_n = 1'b0; req = '0; lock = 1'b0;
    data[0] = 24'h0; data[1] = 24'h0; data[2] = 24'h0; data[3] = 24'h0;

    // Reset and idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_gnt",   32'(gnt),        32'h0);
      chk("idle_disp",  32'(disp_out),   32'h0);
      chk("idle_valid", 32'(disp_valid), 32'h0);
    end

    // Single requester with live data update
    do_reset();
    data[1] = 24'h012345;
    req = 4'b0010;
    cycle();
    chk("single_gnt",  32'(gnt),      32'h2);
    chk("single_disp", 32'(disp_out), 32'h012345);
    for (int i = 0; i < 20; i++) cycle();
    chk("single_keep", 32'(gnt), 32'h2);
    data[1] = 24'h000099;
    cycle();
    chk("single_live", 32'(disp_out), 32'h000099);

    // Table-driven round-robin and LOCK sequence
    do_reset();
    data[0] = 24'hA00000; data[1] = 24'hB11111; data[2] = 24'hC22222; data[3] = 24'hD33333;
    for (int i = 0; i < 30; i++) begin
      req  = vt[i].req;
      lock = vt[i].lock;
      cycle();
      chk("tbl_gnt",   32'(gnt),        32'(vt[i].exp_gnt));
      chk("tbl_valid", 32'(disp_valid), 32'(vt[i].exp_valid));
    end
    lock = 1'b0;

    // Early release, then full release back to idle
    do_reset();
    data[1] = 24'h111111; data[3] = 24'hABCDEF;
    req = 4'b0010;
    cycle();
    chk("rel_first", 32'(gnt), 32'h2);
    req = 4'b1010;
    cycle();
    req = 4'b1000;
    cycle();
    chk("rel_gnt",   32'(gnt),   32'h8);
    chk("rel_owner", 32'(owner), 32'h3);
    req = 4'b0000;
    cycle();
    chk("rel_idle_gnt",   32'(gnt),        32'h0);
    chk("rel_idle_valid", 32'(disp_valid), 32'h0);
    chk("rel_idle_disp",  32'(disp_out),   32'hABCDEF);
    cycle();
    chk("rel_idle_hold",  32'(disp_out),   32'hABCDEF);

    // Asynchronous reset mid-tenure, then first grant goes to requester 0
    data[2] = 24'h222222;
    req = 4'b0100;
    cycle();
    cycle();
    chk("async_pre", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_gnt",   32'(gnt),        32'h0);
    chk("async_disp",  32'(disp_out),   32'h0);
    chk("async_valid", 32'(disp_valid), 32'h0);
    chk("async_owner", 32'(owner),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    cycle();
    chk("async_first", 32'(gnt), 32'h1);
    for (int i = 0; i < 6; i++) cycle();
    chk("async_next", 32'(gnt), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seg_display_arbiter

`default_nettype wire

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Time-shares the single 24-bit seven-segment display datapath between up to NUM_REQ requesters (e.g. sample value, FIR output, debug counter).
- Grants the display round-robin, with a guaranteed minimum dwell per owner so each value stays readable.
- Drives the 24-bit value input of the segment display block, registered.
- Sits between the processing blocks and the segment display at top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DWELL_CYCLES, 50000000, minimum cycles an owner holds the display (1 s at 50 MHz); must be >= 2
CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES
OWN_W, 2, owner index width; equals clog2(NUM_REQ)

Ports:
CLK  in  1  system clock; single clock domain
RST_N  in  1  reset, asynchronous assert, active-low
REQ  in  NUM_REQ  per-requester display request, level-sensitive
REQ_DATA  in  24*NUM_REQ  requester i's value in bits [24i+23:24i]
LOCK  in  1  while high, current owner is never pre-empted by dwell expiry
GNT  out  NUM_REQ  one-hot grant; all-zero when idle
OWNER  out  OWN_W  index of current or last owner
DISP_OUT  out  24  value to segment display input
DISP_VALID  out  1  high while a grant is active

Behaviour:
Reset (RST_N low, asynchronous):
- GNT=0, OWNER=0, DISP_OUT=0, DISP_VALID=0.
- Dwell counter=0, RR pointer=0, state=IDLE.
- Applies immediately, including mid-tenure; first grant after reset favours requester 0.

States IDLE, HOLD. All outputs are registered.

IDLE:
- If any REQ bit is set, pick the winner by round-robin search starting at (pointer+1) mod NUM_REQ; after reset the search starts at 0.
- On the next edge: GNT=onehot(winner), OWNER=winner, DISP_OUT=REQ_DATA[winner], DISP_VALID=1, counter=DWELL_CYCLES-1, pointer=winner, state=HOLD.
- Latency: REQ sampled high at edge t gives GNT and DISP_OUT at edge t+1.
- With no request: outputs hold, DISP_OUT keeps the last value, DISP_VALID=0.

HOLD:
- Every cycle, DISP_OUT <= REQ_DATA[OWNER], so live owner data is shown with 1-cycle latency.
- Counter decrements while nonzero and saturates at 0.
- Owner drops REQ (any counter value): tenure ends at the next edge.
  - Another request pending: grant it via RR from pointer+1, reload counter, stay in HOLD.
  - Otherwise: GNT=0, DISP_VALID=0, state=IDLE, DISP_OUT holds its last value.
- Counter==0, LOCK low, owner still requesting:
  - Another requester pending: switch to the RR winner at the next edge and reload counter.
  - Only the owner is requesting: reload counter and keep the owner (no glitch on GNT).
- Counter==0 with LOCK high: no switch; counter stays 0. Switch happens on the first cycle LOCK is low (if others are pending).
- Simultaneous events:
  - Owner drop and expiry in the same cycle are handled as a drop.
  - A drop while LOCK is high still releases.
- The current owner is never chosen by an RR search while other requesters are pending, so no requester starves when LOCK is low.
- GNT is always one-hot or zero; OWNER always equals the index of GNT when DISP_VALID=1.

Arithmetic:
- Requester index arithmetic is mod NUM_REQ.
- Indices >= NUM_REQ are unreachable.

Decomposition:
Shared package (seg_display_pkg):
- DISP_W=24.
- State encoding IDLE/HOLD.
- Default DWELL_CYCLES constant.

Sub-module rr_pick (combinational):
- Inputs: REQ vector, start index, exclude-owner enable.
- Outputs: found flag and winner index.
- Used for both the IDLE grant and the HOLD switch.
- Everything else (FSM, counter, output registers) stays in seg_display_arbiter.

Test Plan (NUM_REQ=4, DWELL_CYCLES=4):
1. Reset/idle: RST_N low then high, REQ=0 for 10 cycles -> GNT=0, DISP_OUT=0, DISP_VALID=0 throughout.
2. Single requester: REQ=0010, REQ_DATA[1]=0x012345 -> GNT=0010 one cycle later, DISP_OUT=0x012345, no GNT change over 20 cycles. Changing data to 0x000099 appears on DISP_OUT one cycle later.
3. Round-robin: REQ=1011 held -> owners 0,1,3,0,… each held exactly 4 cycles, requester 2 never granted.
4. Early release: owner 1 drops REQ at dwell cycle 2 while REQ[3]=1 -> GNT=1000 next edge, counter reloaded. If all drop, the block goes to IDLE and DISP_OUT holds its last value.
5. LOCK: owner 0 granted, LOCK=1, REQ=0111 for 12 cycles -> GNT stays 0001. Deassert LOCK -> GNT=0010 next edge.
6. Async reset mid-HOLD: pull RST_N low between edges -> outputs clear immediately. After release with REQ=1111, requester 0 is granted first.
